// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, LCR word-length
// encodings, bit-time tick constants and frame helper functions used by
// both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  // LCR[1:0] word-length select
  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  // Bit durations in 16x baud ticks
  localparam int TICKS_BIT = 16;
  localparam int TICKS_1P5 = 24;
  localparam int TICKS_2   = 32;

  // Frame format captured at the start of each frame. The parity bit is
  // resolved at load time so later LCR writes cannot disturb the frame.
  typedef struct packed {
    logic [1:0] wls;
    logic       pen;
    logic       stb;
    logic       par;
  } tx_fmt_t;

  // Mask selecting the 5..8 valid data bits for a word length
  function automatic logic [7:0] wls_mask(input logic [1:0] wls);
    logic [7:0] mask;
    case (wls)
      WLS_5:   mask = 8'h1F;
      WLS_6:   mask = 8'h3F;
      WLS_7:   mask = 8'h7F;
      WLS_8:   mask = 8'hFF;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

  // Parity over the valid data bits only; stick parity forces ~eps
  function automatic logic parity_bit(input logic [7:0] data,
                                      input logic [1:0] wls,
                                      input logic       eps,
                                      input logic       sticky);
    logic [7:0] masked;
    masked = data & wls_mask(wls);
    if (sticky)   return ~eps;
    else if (eps) return ^masked;
    else          return ~^masked;
  endfunction

  // Count reload for the stop period: 1, 1.5 (5-bit words) or 2 stop bits
  function automatic logic [4:0] stop_reload(input logic [1:0] wls,
                                             input logic       stb);
    if (!stb)              return 5'(TICKS_BIT - 1);
    else if (wls == WLS_5) return 5'(TICKS_1P5 - 1);
    else                   return 5'(TICKS_2 - 1);
  endfunction

endpackage

// File: rtl/uart_tx_top.sv
// UART transmit serializer: pops characters from a first-word-fall-through
// TX FIFO on baud ticks and shifts start, data, optional parity and stop
// bits onto tx. All state changes happen only on baud_pulse clocks.
module uart_tx_top
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       pen,
  input  logic       eps,
  input  logic       sticky_parity,
  input  logic       stb,
  input  logic [1:0] wls,
  input  logic       set_break,
  input  logic       fifo_empty,
  input  logic [7:0] din,
  output logic       pop,
  output logic       tx,
  output logic       busy
);

  localparam logic [4:0] BIT_RELOAD = 5'(TICKS_BIT - 1);

  tx_state_e  state_q, state_d;
  logic [4:0] count_q, count_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;
  logic       tx_q, tx_d;
  tx_fmt_t    fmt_q, fmt_d;
  logic       pop_d;
  logic       load_frame;

  // Next-state, datapath and pop strobe for the frame sequencer
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    count_d    = count_q;
    bitcnt_d   = bitcnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    fmt_d      = fmt_q;
    pop_d      = 1'b0;
    load_frame = 1'b0;

    if (baud_pulse) begin
      if (state_q != TX_IDLE && count_q != 5'd0) begin
        count_d = count_q - 5'd1;
      end else begin
        case (state_q)
          TX_IDLE: begin
            load_frame = !fifo_empty;
          end
          TX_START: begin
            tx_d     = shift_q[0];
            bitcnt_d = 3'd4 + {1'b0, fmt_q.wls};
            count_d  = BIT_RELOAD;
            state_d  = TX_DATA;
          end
          TX_DATA: begin
            if (bitcnt_q != 3'd0) begin
              shift_d  = {1'b0, shift_q[7:1]};
              tx_d     = shift_q[1];
              bitcnt_d = bitcnt_q - 3'd1;
              count_d  = BIT_RELOAD;
            end else if (fmt_q.pen) begin
              tx_d    = fmt_q.par;
              count_d = BIT_RELOAD;
              state_d = TX_PARITY;
            end else begin
              tx_d    = 1'b1;
              count_d = stop_reload(fmt_q.wls, fmt_q.stb);
              state_d = TX_STOP;
            end
          end
          TX_PARITY: begin
            tx_d    = 1'b1;
            count_d = stop_reload(fmt_q.wls, fmt_q.stb);
            state_d = TX_STOP;
          end
          TX_STOP: begin
            // Chain straight into the next start bit when data is waiting
            load_frame = !fifo_empty;
            if (fifo_empty) state_d = TX_IDLE;
          end
          default: state_d = TX_IDLE;
        endcase
      end
    end

    if (load_frame) begin
      pop_d   = 1'b1;
      shift_d = din;
      fmt_d   = '{wls: wls, pen: pen, stb: stb,
                  par: parity_bit(din, wls, eps, sticky_parity)};
      tx_d    = 1'b0;
      count_d = BIT_RELOAD;
      state_d = TX_START;
    end
  end

  // State and datapath registers; async reset returns the line to idle-high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= TX_IDLE;
      count_q  <= 5'd0;
      bitcnt_q <= 3'd0;
      shift_q  <= 8'h00;
      tx_q     <= 1'b1;
      fmt_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      state_q  <= state_d;
      count_q  <= count_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      fmt_q    <= fmt_d;
    end
  end

  // Pop is gated by rst so a reset can never consume a FIFO entry
  assign pop  = pop_d & ~rst;
  assign busy = (state_q != TX_IDLE) | pop;
  assign tx   = tx_q & ~set_break;

endmodule

// File: tb/tb_uart_tx_top.sv
// Directed self-checking bench for uart_tx_top: per-scenario tasks with a
// queue-backed FWFT FIFO model and a baud strobe every 6 clocks.
module tb_uart_tx_top;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_pulse = 1'b0;
  logic       pen = 1'b0;
  logic       eps = 1'b0;
  logic       sticky_parity = 1'b0;
  logic       stb = 1'b0;
  logic [1:0] wls = 2'b11;
  logic       set_break = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] din = 8'h00;
  logic       pop;
  logic       tx;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int pop_count = 0;
  int pop_viol = 0;
  logic pop_pend = 1'b0;
  logic [7:0] fifo_q[$];

  uart_tx_top dut (
    .clk           (clk),
    .rst           (rst),
    .baud_pulse    (baud_pulse),
    .pen           (pen),
    .eps           (eps),
    .sticky_parity (sticky_parity),
    .stb           (stb),
    .wls           (wls),
    .set_break     (set_break),
    .fifo_empty    (fifo_empty),
    .din           (din),
    .pop           (pop),
    .tx            (tx),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // One-clock baud strobe every 6 clocks
  initial begin : baud_gen
    forever begin
      repeat (5) @(posedge clk);
      #1 baud_pulse = 1'b1;
      @(posedge clk);
      #1 baud_pulse = 1'b0;
    end
  end

  // Observe pop between edges; flag illegal pops
  initial begin : pop_monitor
    forever begin
      @(negedge clk);
      if (pop === 1'b1) begin
        if (!baud_pulse || fifo_empty) pop_viol++;
        pop_count++;
        pop_pend = 1'b1;
      end
    end
  end

  // FIFO head advances just after the edge that consumed it
  initial begin : fifo_model
    forever begin
      @(posedge clk);
      #1;
      if (pop_pend) begin
        void'(fifo_q.pop_front());
        pop_pend = 1'b0;
        refresh_fifo();
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic refresh_fifo();
    fifo_empty = (fifo_q.size() == 0);
    din = fifo_empty ? 8'h00 : fifo_q[0];
  endtask

  // Push away from both clock edges and the baud strobe transition
  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    refresh_fifo();
  endtask

  task automatic wait_pulse();
    do @(negedge clk); while (!baud_pulse);
  endtask

  task automatic wait_pop(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pop !== 1'b1 && n < 200);
    checks++;
    if (pop !== 1'b1) begin
      errors++;
      $display("FAIL %s_pop: got pop=%b want 1 within 200 clks", name, pop);
    end
  endtask

  // Sample tx at mid-bit (pulse 16k+8) and AND busy across n pulses
  task automatic collect(input int n, output logic [31:0] bits,
                         output logic busy_all);
    bits = '0;
    busy_all = 1'b1;
    for (int p = 1; p <= n; p++) begin
      wait_pulse();
      if (p % 16 == 8) bits[p / 16] = tx;
      if (busy !== 1'b1) busy_all = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || pop !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got tx=%b busy=%b pop=%b want 1 0 0", tx, busy, pop);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) wait_pulse();
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || pop_count !== 0) begin
      errors++;
      $display("FAIL reset_idle: got tx=%b busy=%b pops=%0d want 1 0 0", tx, busy, pop_count);
    end
  endtask

  task automatic test_8o1();
    logic [31:0] bits;
    logic        ba;
    int          pc0;
    wls = 2'b11; pen = 1'b1; eps = 1'b0; sticky_parity = 1'b0; stb = 1'b0;
    pc0 = pop_count;
    sync();
    push(8'h45);
    wait_pop("8o1");
    checks++;
    if (busy !== 1'b1 || tx !== 1'b1) begin
      errors++;
      $display("FAIL 8o1_pop_clk: got busy=%b tx=%b want 1 1", busy, tx);
    end
    @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b0) begin
      errors++;
      $display("FAIL 8o1_latency: got tx=%b want 0 one clk after pop", tx);
    end
    collect(176, bits, ba);
    checks++;
    if (bits[10:0] !== 11'b1_0_01000101_0) begin
      errors++;
      $display("FAIL 8o1_bits: got %b want 10010001010", bits[10:0]);
    end
    checks++;
    if (ba !== 1'b1) begin
      errors++;
      $display("FAIL 8o1_busy_frame: got busy gap want continuous");
    end
    wait_pulse();
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL 8o1_end: got busy=%b tx=%b want 0 1", busy, tx);
    end
    checks++;
    if (pop_count - pc0 !== 1) begin
      errors++;
      $display("FAIL 8o1_pops: got %0d want 1", pop_count - pc0);
    end
  endtask

  task automatic test_5n15();
    logic [31:0] bits;
    logic        ba;
    wls = 2'b00; pen = 1'b0; stb = 1'b1;
    sync();
    push(8'hFF);
    wait_pop("5n15");
    collect(120, bits, ba);
    checks++;
    if (bits[7:0] !== 8'b1111_1110) begin
      errors++;
      $display("FAIL 5n15_bits: got %b want 11111110", bits[7:0]);
    end
    checks++;
    if (ba !== 1'b1) begin
      errors++;
      $display("FAIL 5n15_stop_len: got busy gap want busy through pulse 120");
    end
    wait_pulse();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL 5n15_end: got busy=%b want 0 at pulse 121", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] bits;
    logic        ba;
    int          pc0;
    wls = 2'b11; pen = 1'b0; stb = 1'b0;
    pc0 = pop_count;
    sync();
    push(8'hA5);
    push(8'h3C);
    wait_pop("b2b");
    collect(320, bits, ba);
    checks++;
    if (bits[19:0] !== {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0}) begin
      errors++;
      $display("FAIL b2b_bits: got %b want %b", bits[19:0],
               {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0});
    end
    checks++;
    if (ba !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy: got busy gap want continuous 320 pulses");
    end
    checks++;
    if (pop_count - pc0 !== 2) begin
      errors++;
      $display("FAIL b2b_pops: got %0d want 2", pop_count - pc0);
    end
    wait_pulse();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_parity();
    logic [31:0] bits;
    logic        ba;
    // {sticky, eps, data, expected parity}, all 7-bit words
    logic [10:0] vec [4];
    vec[0] = {1'b1, 1'b0, 8'h00, 1'b1};
    vec[1] = {1'b1, 1'b1, 8'h00, 1'b0};
    vec[2] = {1'b0, 1'b1, 8'h07, 1'b1};
    vec[3] = {1'b0, 1'b0, 8'h07, 1'b0};
    wls = 2'b10; pen = 1'b1; stb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sticky_parity = vec[i][10];
      eps = vec[i][9];
      sync();
      push(vec[i][8:1]);
      wait_pop("parity");
      collect(160, bits, ba);
      checks++;
      if (bits[9:0] !== {1'b1, vec[i][0], vec[i][7:1], 1'b0}) begin
        errors++;
        $display("FAIL parity_%0d: got %b want %b", i, bits[9:0],
                 {1'b1, vec[i][0], vec[i][7:1], 1'b0});
      end
      wait_pulse();
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL parity_%0d_end: got busy=%b want 0", i, busy);
      end
    end
    sticky_parity = 1'b0;
    eps = 1'b0;
  endtask

  task automatic test_break();
    logic brk_ok;
    logic after_ok;
    wls = 2'b11; pen = 1'b0; stb = 1'b0;
    brk_ok = 1'b1;
    after_ok = 1'b1;
    sync();
    push(8'hFF);
    wait_pop("break");
    for (int p = 1; p <= 160; p++) begin
      wait_pulse();
      if (p == 66) set_break = 1'b1;
      if (p == 106) set_break = 1'b0;
      #1;
      if (p >= 66 && p < 106 && tx !== 1'b0) brk_ok = 1'b0;
      if ((p == 106 || p == 120 || p == 152) && tx !== 1'b1) after_ok = 1'b0;
      if (busy !== 1'b1) after_ok = 1'b0;
    end
    checks++;
    if (brk_ok !== 1'b1) begin
      errors++;
      $display("FAIL break_low: got tx high during break want 0");
    end
    checks++;
    if (after_ok !== 1'b1) begin
      errors++;
      $display("FAIL break_release: got wrong tx/busy after release want 1 1");
    end
    wait_pulse();
    checks++;
    if (busy !== 1'b0 || tx !== 1'b1) begin
      errors++;
      $display("FAIL break_timing: got busy=%b tx=%b want 0 1 at pulse 161", busy, tx);
    end
  endtask

  task automatic test_rst_mid();
    logic idle_ok;
    int   pc0;
    wls = 2'b11; pen = 1'b0; stb = 1'b0;
    idle_ok = 1'b1;
    sync();
    push(8'h00);
    wait_pop("rst_mid");
    pc0 = pop_count;
    for (int p = 1; p <= 88; p++) wait_pulse();
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: got tx=%b busy=%b want 0 1 in data bit 4", tx, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || pop !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: got tx=%b busy=%b pop=%b want 1 0 0", tx, busy, pop);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int p = 0; p < 60; p++) begin
      wait_pulse();
      if (tx !== 1'b1 || busy !== 1'b0) idle_ok = 1'b0;
    end
    checks++;
    if (idle_ok !== 1'b1) begin
      errors++;
      $display("FAIL rst_idle: got activity after reset want tx=1 busy=0");
    end
    checks++;
    if (pop_count !== pc0) begin
      errors++;
      $display("FAIL rst_pops: got %0d extra pops want 0", pop_count - pc0);
    end
  endtask

  initial begin : main
    test_reset();
    test_8o1();
    test_5n15();
    test_back_to_back();
    test_parity();
    test_break();
    test_rst_mid();
    checks++;
    if (pop_viol !== 0) begin
      errors++;
      $display("FAIL pop_rules: got %0d pops off-pulse or while empty want 0", pop_viol);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_top.md
# uart_tx_top

Transmit serializer of the 16550-compatible UART: pops characters from the TX FIFO (THR side) and drives them onto the serial `tx` line. Each frame is start bit, 5–8 data bits LSB first, an optional parity bit, and 1, 1.5 or 2 stop bits. It shares the 16x-oversampled `baud_pulse` from the baud generator with `uart_rx_top` and takes its frame format from the LCR fields.

## Interface
Parameters: none (frame format is runtime, from LCR).

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- baud_pulse  in  1  one-clk strobe at 16x baud rate
- pen  in  1  parity enable (LCR[3])
- eps  in  1  even parity select (LCR[4])
- sticky_parity  in  1  stick parity (LCR[5])
- stb  in  1  stop bits: 0 = 1 stop; 1 = 2 stops, or 1.5 when wls=00 (LCR[2])
- wls  in  2  word length: 00=5, 01=6, 10=7, 11=8 bits (LCR[1:0])
- set_break  in  1  force tx low (LCR[6])
- fifo_empty  in  1  TX FIFO empty
- din  in  8  TX FIFO head, first-word-fall-through
- pop  out  1  one-clk FIFO read strobe
- tx  out  1  serial output, idle high
- busy  out  1  frame in progress; ~busy & fifo_empty = TEMT

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Tick counter `count` is 5 bits. Data bit counter `bitcnt` is 3 bits.
- IDLE: on a baud_pulse with fifo_empty=0: pop=1 for that clk, latch din into the shift register, latch wls/pen/eps/sticky_parity/stb, tx<=0, count<=15, enter START.
- LCR changes mid-frame take effect at the next frame only.
- Every state decrements count on each baud_pulse. The state advances on a baud_pulse with count==0, and tx updates on that same edge. Each bit is therefore exactly 16 baud_pulses. A 1.5 stop bit is 24.
- START→DATA: tx<=shift[0], bitcnt<=4+wls.
- DATA: at count==0, if bitcnt!=0: shift right, tx<=next bit, bitcnt-1. Else go to PARITY if pen, otherwise STOP.
- Parity is computed over the N=5+wls latched data bits only; upper bits are masked.
  - sticky=0, eps=0: odd parity, bit = ~^data.
  - sticky=0, eps=1: even parity, bit = ^data.
  - sticky=1: bit = ~eps.
- STOP: tx=1. Duration is 16 ticks, or 32 (stb=1, wls!=00), or 24 (stb=1, wls=00). Load count accordingly: 15, 31 or 23.
- End of STOP: if fifo_empty=0, pop and go straight to START with tx<=0, with no idle gap. Otherwise go to IDLE.
- set_break=1: tx output forced 0 combinationally-after-register (tx_reg & ~set_break). The FSM and pops continue unchanged.
- busy=1 from the pop clk through the last stop tick. It is 0 in IDLE.

## Timing
- Reset values: tx=1, pop=0, busy=0, state IDLE, count=0, bitcnt=0.
- rst mid-frame: tx=1 immediately (async). The frame is abandoned and no further pop occurs. The popped character is lost.
- Latency: tx falls one clk after the pop clk. pop is never asserted on a clk without baud_pulse.
- Frame length in baud_pulses: 16·(1+N+pen) + stop ticks.
- pop is never asserted while fifo_empty=1. At most one pop per frame.
- Transitions happen only on baud_pulse clks. Between pulses all registers hold except pop, which self-clears.

## Structure
- Shared package `uart_pkg`:
  - tx state enum.
  - WLS encodings.
  - Tick constants TICKS_BIT=16, TICKS_1P5=24, TICKS_2=32.
  - A `parity_bit(data, wls, eps, sticky)` function, to be reused by `uart_rx_top`.
- No sub-module needed. The shift register, counters and FSM live in uart_tx_top.
- Bench: baud_pulse every 6 clks.

## Test plan
- wls=11, pen=1, eps=0, sticky=0, stb=0, din=0x45 → tx sequence 0,1,0,1,0,0,0,1,0,parity 0,stop 1, each 16 pulses (176 total). Exactly one pop. busy low after stop.
- wls=00, pen=0, stb=1, din=0xFF → 0,1,1,1,1,1, then stop held 24 pulses (120 total). Parity bit absent.
- Two bytes 0xA5, 0x3C queued, 8N1 → second start bit begins on the pulse ending the first stop, no gap. Two pops. busy continuous for 320 pulses.
- sticky=1 with eps=0, then eps=1, on 7-bit 0x00 → parity bit 1, then 0. Even/odd on 0x07 (wls=10) → eps=1 gives 1, eps=0 gives 0.
- set_break asserted during data bit 3 for 40 pulses → tx=0 throughout. Frame timing unchanged. tx follows the FSM after release.
- rst pulsed mid data bit 4 → tx=1 within the same clk, busy=0, no pop. With fifo_empty=1 after release, tx stays 1 indefinitely.
